// File: rtl/phase_timer.sv
// Seconds timer for the traffic-light controller: paces green/yellow phases, drives ctrl, and exports a BCD countdown.
// Latency: ctrl is combinational from the expire register; BCD and sync_err update one edge after the tick or mismatch cycle.
module phase_timer #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int GREEN_SEC  = 30,
    parameter int YELLOW_SEC = 3,
    parameter int PRE_W      = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       yellow_on,
    input  logic       pause,
    output logic       ctrl,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       sync_err
);

    localparam logic PH_GREEN  = 1'b0;
    localparam logic PH_YELLOW = 1'b1;

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [3:0]       G_TENS   = 4'(GREEN_SEC / 10);
    localparam logic [3:0]       G_ONES   = 4'(GREEN_SEC % 10);
    localparam logic [3:0]       Y_TENS   = 4'(YELLOW_SEC / 10);
    localparam logic [3:0]       Y_ONES   = 4'(YELLOW_SEC % 10);

    logic [PRE_W-1:0] pre;
    logic             phase;
    logic             expire;

    logic             tick;
    logic             last_sec;
    logic             desync;
    logic [3:0]       dec_tens;
    logic [3:0]       dec_ones;
    logic [3:0]       exp_tens;
    logic [3:0]       exp_ones;
    logic [3:0]       syn_tens;
    logic [3:0]       syn_ones;

    assign tick     = (pre == PRE_MAX) && !pause;
    assign last_sec = (sec_tens == 4'd0) && (sec_ones == 4'd1);
    // Suppressed during the expire cycle: the controller has not yet seen the advance edge.
    assign desync   = !expire && (yellow_on != phase);

    assign ctrl = yellow_on ? expire : ~expire;

    always_comb begin
        dec_tens = sec_tens;
        dec_ones = sec_ones - 4'd1;
        if (sec_ones == 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = sec_tens - 4'd1;
        end
    end

    always_comb begin
        exp_tens = G_TENS;
        exp_ones = G_ONES;
        if (~phase == PH_YELLOW) begin
            exp_tens = Y_TENS;
            exp_ones = Y_ONES;
        end
        syn_tens = G_TENS;
        syn_ones = G_ONES;
        if (yellow_on == PH_YELLOW) begin
            syn_tens = Y_TENS;
            syn_ones = Y_ONES;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre      <= '0;
            phase    <= PH_GREEN;
            expire   <= 1'b0;
            sync_err <= 1'b0;
            sec_tens <= G_TENS;
            sec_ones <= G_ONES;
        end else begin
            expire   <= 1'b0;
            sync_err <= 1'b0;
            if (desync) begin
                phase    <= yellow_on;
                sec_tens <= syn_tens;
                sec_ones <= syn_ones;
                pre      <= '0;
                sync_err <= 1'b1;
            end else if (tick && last_sec) begin
                expire   <= 1'b1;
                phase    <= ~phase;
                sec_tens <= exp_tens;
                sec_ones <= exp_ones;
                pre      <= '0;
            end else if (tick) begin
                pre      <= '0;
                sec_tens <= dec_tens;
                sec_ones <= dec_ones;
            end else if (!pause) begin
                pre <= pre + 1'b1;
            end
        end
    end

endmodule
